// File: rtl/dm_pkg.sv
// dm_pkg: shared FSM state and access-type codes for the data-memory access controller
package dm_pkg;
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    localparam logic [1:0] MT_WORD = 2'b00;
    localparam logic [1:0] MT_HALF = 2'b01;
    localparam logic [1:0] MT_BYTE = 2'b10;
endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align: little-endian byte-lane alignment for stores and extraction/extension for loads
//   typ_i   access type (MT_*; 2'b11 behaves as word)
//   off_i   byte offset within the word
//   sign_i  sign-extend half/byte loads
//   sdata_i store data before lane replication
//   rdata_i read word from memory
//   be_o    byte enables, bit k = byte k
//   wdata_o lane-replicated store data
//   ldata_o aligned and extended load value
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  typ_i,
    input  logic [1:0]  off_i,
    input  logic        sign_i,
    input  logic [31:0] sdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o
);
    logic [31:0] sh;
    logic        is_b, is_h;
    assign is_b = typ_i == MT_BYTE;
    assign is_h = typ_i == MT_HALF;
    assign sh = rdata_i >> {off_i, 3'b000};
    assign be_o = is_b ? 4'b0001 << off_i : is_h ? (off_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata_o = is_b ? {4{sdata_i[7:0]}} : is_h ? {2{sdata_i[15:0]}} : sdata_i;
    assign ldata_o = is_b ? {{24{sign_i & sh[7]}}, sh[7:0]}
                   : is_h ? {{16{sign_i & sh[15]}}, sh[15:0]} : rdata_i;
endmodule

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: sequences M-stage loads/stores onto a req/ack memory port with stall and timeout
//   clk_i/rst_ni           clock, async active-low reset
//   m_*_i, w_trans_i       M-stage access request and store-data sources
//   fwd_sel_i              1 = store w_trans_i, 0 = store m_r2_i
//   stall_o, addr_exc_o    pipeline freeze and misalignment flag (combinational)
//   mem_*_o, mem_*_i       registered memory request / completion
//   load_data_o            extracted load result
//   load_valid_o/bus_err_o one-cycle pulses in DONE
module dm_access_ctrl
    import dm_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        m_valid_i,
    input  logic        m_we_i,
    input  logic [1:0]  m_type_i,
    input  logic        m_sign_i,
    input  logic [31:0] m_addr_i,
    input  logic [31:0] m_r2_i,
    input  logic [31:0] w_trans_i,
    input  logic        fwd_sel_i,
    output logic        stall_o,
    output logic        addr_exc_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        bus_err_o
);
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       off_q, typ_q;
    logic             sign_q, req_q, we_q, lv_q, err_q;
    logic [31:0]      addr_q, wdata_q, ldata_q;
    logic [3:0]       be_q;
    logic             idle, mis, accept, timeout;
    logic [3:0]       be;
    logic [31:0]      wdata, ldata;

    assign idle    = state_q == IDLE;
    assign mis     = m_type_i == MT_HALF ? m_addr_i[0] : m_type_i == MT_BYTE ? 1'b0 : |m_addr_i[1:0];
    assign accept  = idle & m_valid_i & !mis;
    assign timeout = cnt_q == CNT_W'(TIMEOUT_CYC - 1);

    assign addr_exc_o   = idle & m_valid_i & mis;
    assign stall_o      = accept | (state_q == REQ);
    assign mem_req_o    = req_q;
    assign mem_we_o     = we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_be_o     = be_q;
    assign load_data_o  = ldata_q;
    assign load_valid_o = lv_q;
    assign bus_err_o    = err_q;

    // One aligner serves both directions: live M-stage fields while IDLE
    // (store alignment), latched fields while REQ (load extraction).
    dm_lane_align u_align (
        .typ_i   (idle ? m_type_i : typ_q),
        .off_i   (idle ? m_addr_i[1:0] : off_q),
        .sign_i  (idle ? m_sign_i : sign_q),
        .sdata_i (fwd_sel_i ? w_trans_i : m_r2_i),
        .rdata_i (mem_rdata_i),
        .be_o    (be),
        .wdata_o (wdata),
        .ldata_o (ldata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            off_q   <= '0;
            typ_q   <= '0;
            sign_q  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            ldata_q <= '0;
            lv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                    we_q    <= m_we_i;
                    addr_q  <= {m_addr_i[31:2], 2'b00};
                    be_q    <= be;
                    wdata_q <= wdata;
                    off_q   <= m_addr_i[1:0];
                    typ_q   <= m_type_i;
                    sign_q  <= m_sign_i;
                    cnt_q   <= '0;
                end
                REQ: if (mem_ack_i) begin
                    state_q <= DONE;
                    req_q   <= 1'b0;
                    ldata_q <= ldata;
                    lv_q    <= !we_q;
                end else if (timeout) begin
                    state_q <= DONE;
                    req_q   <= 1'b0;
                    ldata_q <= '0;
                    err_q   <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    lv_q    <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: directed checks of the data-memory access controller
module tb_dm_access_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        m_valid = 0, m_we = 0, m_sign = 0, fwd_sel = 0, mem_ack = 0;
    logic [1:0]  m_type = 0;
    logic [31:0] m_addr = 0, m_r2 = 0, w_trans = 0, mem_rdata = 0;
    logic        stall, addr_exc, mem_req, mem_we, load_valid, bus_err;
    logic [31:0] mem_addr, mem_wdata, load_data;
    logic [3:0]  mem_be;
    logic        t_stall, t_addr_exc, t_mem_req, t_mem_we, t_load_valid, t_bus_err;
    logic [31:0] t_mem_addr, t_mem_wdata, t_load_data;
    logic [3:0]  t_mem_be;
    int checks = 0, failures = 0, reqcnt;

    always #5 clk = ~clk;

    dm_access_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .m_valid_i(m_valid), .m_we_i(m_we), .m_type_i(m_type),
        .m_sign_i(m_sign), .m_addr_i(m_addr), .m_r2_i(m_r2), .w_trans_i(w_trans),
        .fwd_sel_i(fwd_sel), .stall_o(stall), .addr_exc_o(addr_exc), .mem_req_o(mem_req),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
        .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata), .load_data_o(load_data),
        .load_valid_o(load_valid), .bus_err_o(bus_err)
    );

    dm_access_ctrl #(.TIMEOUT_CYC(4), .CNT_W(8)) dut_to (
        .clk_i(clk), .rst_ni(rst_n), .m_valid_i(m_valid), .m_we_i(m_we), .m_type_i(m_type),
        .m_sign_i(m_sign), .m_addr_i(m_addr), .m_r2_i(m_r2), .w_trans_i(w_trans),
        .fwd_sel_i(fwd_sel), .stall_o(t_stall), .addr_exc_o(t_addr_exc), .mem_req_o(t_mem_req),
        .mem_we_o(t_mem_we), .mem_addr_o(t_mem_addr), .mem_wdata_o(t_mem_wdata), .mem_be_o(t_mem_be),
        .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata), .load_data_o(t_load_data),
        .load_valid_o(t_load_valid), .bus_err_o(t_bus_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #3;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_req got %b exp 0", mem_req); end
        checks++; if ({mem_be, mem_wdata, mem_addr} !== 68'h0) begin failures++; $display("FAIL reset_fields got %h %h %h exp 0", mem_be, mem_wdata, mem_addr); end
        checks++; if ({stall, load_valid, bus_err, load_data} !== 35'h0) begin failures++; $display("FAIL reset_outs got %b%b%b %h exp 0", stall, load_valid, bus_err, load_data); end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_store_word;
        m_valid = 1; m_we = 1; m_type = 2'b00; m_addr = 32'h10; m_r2 = 32'hDEADBEEF; fwd_sel = 0;
        #1;
        checks++; if (stall !== 1'b1 || addr_exc !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL sw_c0 got stall=%b exc=%b req=%b exp 1 0 0", stall, addr_exc, mem_req); end
        tick; m_valid = 0; m_r2 = 0; #1;
        checks++; if ({mem_req, mem_we, stall} !== 3'b111) begin failures++; $display("FAIL sw_c1_ctl got %b exp 111", {mem_req, mem_we, stall}); end
        checks++; if (mem_be !== 4'b1111 || mem_wdata !== 32'hDEADBEEF || mem_addr !== 32'h10) begin failures++; $display("FAIL sw_c1_data got be=%b wd=%h a=%h exp 1111 deadbeef 10", mem_be, mem_wdata, mem_addr); end
        tick; mem_ack = 1; #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sw_c2_stall got %b exp 1", stall); end
        tick; mem_ack = 0; #1;
        checks++; if ({stall, mem_req, load_valid, bus_err} !== 4'b0000) begin failures++; $display("FAIL sw_done got %b exp 0000", {stall, mem_req, load_valid, bus_err}); end
        tick;
    endtask

    task automatic test_fwd_byte;
        m_valid = 1; m_we = 1; m_type = 2'b10; m_addr = 32'h13; fwd_sel = 1; w_trans = 32'hA5; m_r2 = 32'h12345678;
        tick; m_valid = 0; w_trans = 0; #1;
        checks++; if (mem_be !== 4'b1000 || mem_wdata !== 32'hA5A5A5A5 || mem_addr !== 32'h10) begin failures++; $display("FAIL fb_c1 got be=%b wd=%h a=%h exp 1000 a5a5a5a5 10", mem_be, mem_wdata, mem_addr); end
        tick; mem_ack = 1; #1;
        checks++; if (mem_wdata !== 32'hA5A5A5A5 || mem_req !== 1'b1) begin failures++; $display("FAIL fb_c2 got wd=%h req=%b exp a5a5a5a5 1", mem_wdata, mem_req); end
        tick; mem_ack = 0; fwd_sel = 0; #1;
        checks++; if (load_valid !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL fb_done got lv=%b stall=%b exp 0 0", load_valid, stall); end
        tick;
    endtask

    task automatic test_half_load;
        m_valid = 1; m_we = 0; m_type = 2'b01; m_sign = 1; m_addr = 32'h22; mem_rdata = 32'h80011234;
        tick; m_valid = 0; #1;
        checks++; if (mem_be !== 4'b1100 || mem_we !== 1'b0) begin failures++; $display("FAIL hl_be got be=%b we=%b exp 1100 0", mem_be, mem_we); end
        reqcnt = 0;
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) mem_ack = 1;
            #1;
            reqcnt += int'(mem_req);
            tick;
        end
        mem_ack = 0; #1;
        checks++; if (load_data !== 32'hFFFF8001 || load_valid !== 1'b1) begin failures++; $display("FAIL hl_done got ld=%h lv=%b exp ffff8001 1", load_data, load_valid); end
        checks++; if (reqcnt !== 5 || stall !== 1'b0) begin failures++; $display("FAIL hl_reqcnt got %0d stall=%b exp 5 0", reqcnt, stall); end
        tick;
        checks++; if (load_valid !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL hl_pulse got lv=%b req=%b exp 0 0", load_valid, mem_req); end
        m_sign = 0;
    endtask

    task automatic test_byte_load;
        m_valid = 1; m_we = 0; m_type = 2'b10; m_sign = 0; m_addr = 32'h41; mem_rdata = 32'h11228344;
        tick; m_valid = 0; mem_ack = 1; #1;
        checks++; if (mem_be !== 4'b0010 || mem_addr !== 32'h40) begin failures++; $display("FAIL bl_req got be=%b a=%h exp 0010 40", mem_be, mem_addr); end
        tick; mem_ack = 0; #1;
        checks++; if (load_data !== 32'h00000083 || load_valid !== 1'b1) begin failures++; $display("FAIL bl_done got ld=%h lv=%b exp 00000083 1", load_data, load_valid); end
        tick;
    endtask

    task automatic test_misaligned;
        m_valid = 1; m_we = 0; m_type = 2'b00; m_addr = 32'h05; #1;
        checks++; if (addr_exc !== 1'b1 || stall !== 1'b0) begin failures++; $display("FAIL mis_word got exc=%b stall=%b exp 1 0", addr_exc, stall); end
        tick;
        checks++; if (mem_req !== 1'b0 || addr_exc !== 1'b1) begin failures++; $display("FAIL mis_noreq got req=%b exc=%b exp 0 1", mem_req, addr_exc); end
        m_type = 2'b01; m_addr = 32'h21; #1;
        checks++; if (addr_exc !== 1'b1) begin failures++; $display("FAIL mis_half got %b exp 1", addr_exc); end
        m_type = 2'b10; m_addr = 32'h05; #1;
        checks++; if (addr_exc !== 1'b0 || stall !== 1'b1) begin failures++; $display("FAIL mis_byte_ok got exc=%b stall=%b exp 0 1", addr_exc, stall); end
        m_valid = 0; #1;
        checks++; if (addr_exc !== 1'b0) begin failures++; $display("FAIL mis_novalid got %b exp 0", addr_exc); end
        tick;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL mis_idle got %b exp 0", mem_req); end
    endtask

    task automatic test_timeout;
        m_valid = 1; m_we = 0; m_type = 2'b00; m_addr = 32'h100; mem_rdata = 32'hCAFEF00D;
        tick; m_valid = 0;
        reqcnt = 0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            reqcnt += int'(t_mem_req);
            tick;
        end
        #1;
        checks++; if (reqcnt !== 4 || t_mem_req !== 1'b0) begin failures++; $display("FAIL to_reqcnt got %0d req=%b exp 4 0", reqcnt, t_mem_req); end
        checks++; if (t_bus_err !== 1'b1 || t_load_valid !== 1'b0 || t_load_data !== 32'h0) begin failures++; $display("FAIL to_done got err=%b lv=%b ld=%h exp 1 0 0", t_bus_err, t_load_valid, t_load_data); end
        tick;
        checks++; if (t_bus_err !== 1'b0 || t_stall !== 1'b0) begin failures++; $display("FAIL to_idle got err=%b stall=%b exp 0 0", t_bus_err, t_stall); end
    endtask

    task automatic test_reset_in_req;
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rr_pre got %b exp 1", mem_req); end
        rst_n = 0; #1;
        checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL rr_async got req=%b stall=%b exp 0 0", mem_req, stall); end
        tick; rst_n = 1;
        tick; mem_ack = 1; #1;
        checks++; if (load_valid !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL rr_ack got lv=%b req=%b exp 0 0", load_valid, mem_req); end
        tick; mem_ack = 0; #1;
        checks++; if ({load_valid, bus_err, mem_req, stall} !== 4'b0000) begin failures++; $display("FAIL rr_after got %b exp 0000", {load_valid, bus_err, mem_req, stall}); end
    endtask

    initial begin
        test_reset;
        test_store_word;
        test_fwd_byte;
        test_half_load;
        test_byte_load;
        test_misaligned;
        test_timeout;
        test_reset_in_req;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Sequences every M-stage data-memory access onto a variable-latency memory port using a req/ack handshake.
- Stalls the pipeline while an access is outstanding.
- Captures store data at acceptance: either the M-stage rs2 value or the W-stage forwarded value. The capture is required because W changes while M is stalled.
- Performs byte-lane alignment for stores and extraction/extension for loads, and flags misaligned addresses.

Parameters:
- TIMEOUT_CYC, 255: maximum cycles in REQ without mem_ack before the access is aborted with bus_err.
- CNT_W, 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- m_valid  input  1  M-stage instruction performs a memory access.
- m_we  input  1  1 = store, 0 = load.
- m_type  input  2  00 word, 01 half, 10 byte, 11 treated as word.
- m_sign  input  1  sign-extend loaded half/byte.
- m_addr  input  32  byte address.
- m_r2  input  32  M-stage store data.
- w_trans  input  32  W-stage forwarded data.
- fwd_sel  input  1  1 = store w_trans, 0 = store m_r2.
- stall  output  1  freeze F..M pipeline registers.
- addr_exc  output  1  misaligned access, combinational.
- mem_req  output  1  request to memory, registered.
- mem_we  output  1  write strobe.
- mem_addr  output  32  word address, low two bits forced to 00.
- mem_wdata  output  32  lane-replicated store data.
- mem_be  output  4  byte enables, bit k = byte k.
- mem_ack  input  1  memory completion, sampled only while mem_req = 1.
- mem_rdata  input  32  read word, valid with mem_ack.
- load_data  output  32  aligned and extended load result.
- load_valid  output  1  one-cycle pulse in DONE.
- bus_err  output  1  one-cycle pulse in DONE after a timeout.

Behaviour:
- Reset (async, any state): state IDLE. All registered outputs become 0: mem_req, mem_we, mem_addr, mem_wdata, mem_be, load_data, load_valid, bus_err, counter. A reset in REQ drops mem_req immediately; any later ack is ignored.
- Misalignment: word with addr[1:0] != 0, or half with addr[0] != 0.
  - addr_exc = m_valid & IDLE & misaligned.
  - A misaligned access issues no request and raises no stall.
- stall = (IDLE & m_valid & !misaligned) | REQ. stall is 0 in DONE.
- IDLE:
  - On m_valid & aligned, latch the following and go to REQ:
    - mem_addr = {m_addr[31:2], 2'b00}
    - mem_we = m_we
    - mem_be per lane rule
    - mem_wdata = aligned (fwd_sel ? w_trans : m_r2)
    - byte offset, m_type, m_sign for later load extraction
  - Set mem_req = 1 and clear the counter.
- REQ:
  - mem_req held at 1 with all request fields stable.
  - On mem_ack: capture the extracted load result, clear mem_req, go to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYC-1 without ack: clear mem_req, set the error flag, go to DONE.
- DONE (exactly one cycle):
  - load_valid = !m_we_latched & !err.
  - bus_err = err.
  - On error, load_data = 0.
  - Return to IDLE. Pipeline advances at the end of this cycle.
- Latency: accept at cycle 0, mem_req high from cycle 1, ack at cycle k ≥ 1, DONE at k+1. Minimum 3 cycles per access.
- Lane rules (little-endian):
  - byte: be = 1 << off, wdata = {4{d[7:0]}}.
  - half: be = off[1] ? 1100 : 0011, wdata = {2{d[15:0]}}.
  - word: be = 1111, wdata = d.
- Load extraction:
  - Shift mem_rdata right by 8*off, take 8 or 16 bits, then sign- or zero-extend per m_sign.
  - Word loads pass through unchanged.
- Ignored inputs:
  - mem_ack outside REQ.
  - m_valid and data inputs in REQ and DONE; latched copies are used.
  - A w_trans change after acceptance does not alter mem_wdata.

Decomposition:
- Package dm_pkg:
  - state enum {IDLE, REQ, DONE}.
  - Type codes MT_WORD = 2'b00, MT_HALF = 2'b01, MT_BYTE = 2'b10.
- Sub-module dm_lane_align (combinational), used for both store alignment and load extraction:
  - Inputs: type, offset, sign, store data, read word.
  - Outputs: be, wdata, extracted load value.

Test Plan:
- Store word with fwd_sel = 0: addr 0x0000_0010, m_r2 = 0xDEAD_BEEF, ack on cycle 2 → mem_be = 1111, mem_wdata = 0xDEAD_BEEF, stall high on cycles 0–2, low on cycle 3, load_valid = 0.
- Forwarded store byte: addr 0x13, fwd_sel = 1, w_trans = 0x0000_00A5; w_trans changes to 0x0 after cycle 0 → mem_be = 1000, mem_wdata = 0xA5A5_A5A5 for the whole of REQ.
- Signed half load: addr 0x22, m_sign = 1, mem_rdata = 0x8001_1234 with ack after 5 cycles → load_data = 0xFFFF_8001, load_valid pulses once, mem_req high for exactly 5 cycles.
- Misaligned word load: addr 0x05 → addr_exc = 1, stall = 0, mem_req stays 0.
- Timeout with TIMEOUT_CYC = 4 and no ack → mem_req high for 4 cycles, then bus_err = 1 and load_data = 0 in DONE, then IDLE.
- Reset asserted during REQ, ack arriving after release → mem_req = 0 immediately, state IDLE, stray ack produces no load_valid.
